// File: rtl/regfile_pkg.sv
// Shared register-file constants and types.
package regfile_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREGS  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr, returns a
// one-hot grant and the pointer value to load after that grant.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] ptr_nxt
);

    logic [PW:0]   sum;
    logic [PW-1:0] cur;
    logic          found;

    // First valid requester at or after ptr (modulo N) wins.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        sum     = '0;
        cur     = '0;
        if (en) begin
            for (int unsigned k = 0; k < N; k++) begin
                sum = (PW+1)'(ptr) + (PW+1)'(k);
                if (sum >= (PW+1)'(N)) begin
                    sum = sum - (PW+1)'(N);
                end
                cur = sum[PW-1:0];
                if (!found && req[cur]) begin
                    found    = 1'b1;
                    gnt[cur] = 1'b1;
                    ptr_nxt  = (32'(cur) == N - 1) ? '0 : cur + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port plus a pending-write
// scoreboard for RAW detection. Optional macro R0_ZERO_EN makes register 0
// hard-wired zero (no writes, never pending).
import regfile_pkg::*;

module regfile_write_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   wr_en,
    output reg_addr_t              wr_addr,
    output reg_data_t              wr_data,
    input  logic                   pend_set,
    input  reg_addr_t              pend_addr,
    input  reg_addr_t              rs1_addr,
    input  reg_addr_t              rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic [NREGS-1:0]       pend_vec
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [NREQ-1:0]  gnt;
    logic             transfer;
    logic             wr_go;
    logic             pend_take;
    reg_addr_t        sel_addr;
    reg_data_t        sel_data;
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_arb (
        .req     (req_valid),
        .en      (rst_n & ~hold),
        .ptr     (ptr),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    assign req_ready = gnt;
    assign transfer  = |gnt;

    // Select the granted requester's payload.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Register 0 writes and allocations are suppressed when it is hard-wired.
    always_comb begin
`ifdef R0_ZERO_EN
        wr_go     = transfer && (sel_addr != '0);
        pend_take = pend_set && (pend_addr != '0);
`else
        wr_go     = transfer;
        pend_take = pend_set;
`endif
    end

    // Round-robin pointer advances past each winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= ptr_nxt;
        end
    end

    // Write-port output register; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= wr_go;
            if (transfer) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    // Scoreboard next state: retire the completing write, then allocate (set wins).
    always_comb begin
        pend_nxt = pend;
        if (wr_en) begin
            pend_nxt[wr_addr] = 1'b0;
        end
        if (pend_take) begin
            pend_nxt[pend_addr] = 1'b1;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign pend_vec = pend;
    assign rs1_busy = pend[rs1_addr];
    assign rs2_busy = pend[rs2_addr];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized check of regfile_write_arbiter against a
// cycle-level behavioural model of arbitration, write pipeline and scoreboard.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int unsigned NREQ = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   hold;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wr_en;
    reg_addr_t              wr_addr;
    reg_data_t              wr_data;
    logic                   pend_set;
    reg_addr_t              pend_addr;
    reg_addr_t              rs1_addr;
    reg_addr_t              rs2_addr;
    logic                   rs1_busy;
    logic                   rs2_busy;
    logic [NREGS-1:0]       pend_vec;

    regfile_write_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .pend_vec  (pend_vec)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int        m_ptr;
    bit        m_wr_en;
    int        m_wr_addr;
    int        m_wr_data;
    bit        m_pend[NREGS];
    int        last_gnt;

    bit r0_zero;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit busy_of(input int a);
        if (r0_zero && a == 0) return 1'b0;
        return m_pend[a];
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic step(input int exp_rdy = -1);
        int g;
        logic [NREQ-1:0] er;
        logic [NREGS-1:0] ep;
        int ga;
        int gd;
        #1;
        g  = -1;
        er = '0;
        if (rst_n && !hold) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                int idx;
                idx = (m_ptr + k) % int'(NREQ);
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        for (int r = 0; r < int'(NREGS); r++) ep[r] = m_pend[r];
        chk("req_ready", 32'(req_ready), 32'(er));
        if (exp_rdy >= 0) chk("plan_ready", 32'(req_ready), 32'(exp_rdy));
        chk("wr_en",    32'(wr_en),    32'(m_wr_en));
        chk("wr_addr",  32'(wr_addr),  32'(m_wr_addr));
        chk("wr_data",  32'(wr_data),  32'(m_wr_data));
        chk("pend_vec", 32'(pend_vec), 32'(ep));
        chk("rs1_busy", 32'(rs1_busy), 32'(busy_of(int'(rs1_addr))));
        chk("rs2_busy", 32'(rs2_busy), 32'(busy_of(int'(rs2_addr))));
        last_gnt = g;
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
            for (int r = 0; r < int'(NREGS); r++) m_pend[r] = 0;
        end else begin
            if (m_wr_en) m_pend[m_wr_addr] = 0;
            if (pend_set && !(r0_zero && pend_addr == 0)) m_pend[int'(pend_addr)] = 1;
            if (g >= 0) begin
                ga = int'(req_addr[g*ADDR_W +: ADDR_W]);
                gd = int'(req_data[g*DATA_W +: DATA_W]);
                m_ptr     = (g + 1) % int'(NREQ);
                m_wr_en   = !(r0_zero && ga == 0);
                m_wr_addr = ga;
                m_wr_data = gd;
            end else begin
                m_wr_en = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int d);
        req_valid[i] = v;
        req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        req_data[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    initial begin
`ifdef R0_ZERO_EN
        r0_zero = 1'b1;
`else
        r0_zero = 1'b0;
`endif
        m_ptr = 0; m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0; last_gnt = -1;
        for (int r = 0; r < int'(NREGS); r++) m_pend[r] = 0;
        rst_n = 0; hold = 0; req_valid = '0; req_addr = '0; req_data = '0;
        pend_set = 0; pend_addr = '0; rs1_addr = '0; rs2_addr = '0;
        @(negedge clk);
        // Model starts from reset values; first steps hold reset.
        step(0);
        step(0);
        rst_n = 1;

        // All three valid, held: grants rotate 0,1,2 then back to 0.
        set_req(0, 1, 1, 'h11); set_req(1, 1, 2, 'h22); set_req(2, 1, 3, 'h33);
        step(3'b001);
        step(3'b010);
        step(3'b100);
        step(3'b001);
        req_valid = '0;
        step(0);
        step(0);

        // Only requester 2, payload changing every cycle.
        for (int c = 0; c < 4; c++) begin
            set_req(2, 1, 4 + c, 'hA0 + c);
            step(3'b100);
        end
        req_valid = '0;
        step(0);

        // Hold with everyone valid, then release.
        set_req(0, 1, 6, 'h61); set_req(1, 1, 7, 'h71); set_req(2, 1, 1, 'h81);
        hold = 1;
        step(0); step(0); step(0);
        hold = 0;
        step(3'b001);
        req_valid = '0;
        step(0);

        // Scoreboard: allocate 5, then write it back.
        rs1_addr = 3'd5; rs2_addr = 3'd6;
        pend_set = 1; pend_addr = 3'd5;
        step();
        pend_set = 0;
        set_req(0, 1, 5, 'h55);
        step();
        req_valid = '0;
        step();
        step();
        // Re-allocation coincident with the retiring write keeps busy.
        set_req(1, 1, 5, 'h5A);
        step();
        req_valid = '0;
        pend_set = 1; pend_addr = 3'd5;
        step();
        pend_set = 0;
        step();

        // Fill the scoreboard, register a write, then reset mid-flight.
        for (int r = 0; r < int'(NREGS); r++) begin
            pend_set = 1; pend_addr = ADDR_W'(r);
            if (r == int'(NREGS) - 1) set_req(1, 1, 3, 'h3C);
            step();
        end
        pend_set = 0; req_valid = '0;
        rst_n = 0;
        step(0);
        rst_n = 1;
        set_req(2, 1, 2, 'h2B); set_req(0, 1, 4, 'h4B);
        step(3'b001);
        req_valid = '0;
        step(0);

        // Register 0 writes and allocation.
        rs1_addr = 3'd0;
        pend_set = 1; pend_addr = 3'd0;
        step();
        pend_set = 0;
        set_req(0, 1, 0, 'hAA);
        step();
        req_valid = '0;
        step();
        step();

        // Randomized traffic obeying the valid/ready protocol.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (last_gnt == i || !req_valid[i]) begin
                    set_req(i, $urandom_range(0, 3) != 0,
                            int'($urandom_range(0, NREGS - 1)), int'($urandom_range(0, 255)));
                end
            end
            hold      = ($urandom_range(0, 7) == 0);
            pend_set  = ($urandom_range(0, 2) == 0);
            pend_addr = ADDR_W'($urandom_range(0, NREGS - 1));
            rs1_addr  = ADDR_W'($urandom_range(0, NREGS - 1));
            rs2_addr  = ADDR_W'($urandom_range(0, NREGS - 1));
            rst_n     = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1; hold = 0; pend_set = 0; req_valid = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback sources, e.g. ALU, load unit and debug/config port.
- Arbitration is round-robin with a valid/ready handshake per source.
- The winning write is registered and drives the register file's we/rd/data inputs one cycle later.
- Keeps a per-register pending scoreboard so the issue stage can detect RAW hazards on rs1/rs2 before reading.

Parameters:
- NREQ, 3, number of write requesters (2..8)
- DATA_W, 8, register data width
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- hold  in  1  stall; while high no grant is issued
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*ADDR_W  destination register, slice i
- req_data  in  NREQ*DATA_W  write data, slice i
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready
- wr_en  out  1  to register file we
- wr_addr  out  ADDR_W  to register file rd_in
- wr_data  out  DATA_W  to register file data
- pend_set  in  1  issue stage allocates a destination
- pend_addr  in  ADDR_W  register being allocated
- rs1_addr  in  ADDR_W  issue-stage source 1
- rs2_addr  in  ADDR_W  issue-stage source 2
- rs1_busy  out  1  pending[rs1_addr]
- rs2_busy  out  1  pending[rs2_addr]
- pend_vec  out  NREGS  full scoreboard, for debug

Behaviour:
- Reset (rst_n=0 at posedge):
  - wr_en=0, wr_addr=0, wr_data=0
  - round-robin pointer=0, so requester 0 has highest priority
  - all pending bits 0
  - req_ready forced to 0 while rst_n=0
- Handshake:
  - req_ready is combinational from req_valid, pointer, hold and rst_n.
  - At most one bit of req_ready is high; req_ready[i]=1 only when req_valid[i]=1.
  - A requester holds valid/addr/data stable until its transfer; valid must not drop before ready.
- Arbitration:
  - Search starts at the pointer and proceeds upward modulo NREQ; the first valid requester wins.
  - After a grant to i, pointer <= (i+1) mod NREQ.
  - With no grant (no valid or hold=1) the pointer is unchanged.
  - No requester waits more than NREQ-1 grants.
- Output stage:
  - On a transfer in cycle T: wr_en=1 and wr_addr/wr_data = the granted slice during cycle T+1; the register file captures it at the end of T+1.
  - With no transfer in T, wr_en=0 in T+1 and wr_addr/wr_data hold their previous values.
  - Throughput is one write per cycle; the register file never backpressures.
- hold:
  - Forces req_ready=0 in the same cycle.
  - A write already registered still completes.
- Scoreboard:
  - pend_set=1 sets pending[pend_addr] at the next edge.
  - wr_en=1 clears pending[wr_addr] at the same edge the register file writes.
  - Set and clear of the same address on the same edge: set wins (new producer allocated).
  - rs1_busy and rs2_busy are combinational lookups of the current pending bits.
  - A write to a non-pending register is legal and leaves its bit at 0.
- Reset mid-operation:
  - Any registered write is dropped: wr_en=0 after the edge.
  - Scoreboard clears; ungranted requests are not remembered.

Optional Feature:
- Macro: R0_ZERO_EN
- Defined:
  - Register 0 is hard-wired zero.
  - Requests to addr 0 are granted normally but produce wr_en=0 in T+1.
  - pend_set to addr 0 is ignored, and rs1_busy/rs2_busy are 0 for addr 0.
- Undefined: register 0 behaves like every other register.

Decomposition:
- Package regfile_pkg holds:
  - constants: DATA_W, ADDR_W, NREGS
  - typedefs: reg_addr_t, reg_data_t
- One sub-module, rr_arbiter:
  - parameter N
  - inputs: req, en
  - outputs: one-hot gnt, pointer update
  - Reused later for read-port sharing.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset, then req_valid=3'b111 with addr 1/2/3, data 8'h11/22/33, held: grants in order 0,1,2; wr_en 1 for three consecutive cycles, one cycle after each grant; pointer returns to 0.
- Only requester 2 valid for 4 cycles with changing payload: ready[2]=1 every cycle; wr_data follows each payload with 1-cycle latency; no bubbles.
- hold=1 with all valid for 3 cycles: req_ready=0 and wr_en=0 from the second cycle on; hold released: grant resumes at the pointer value saved before hold.
- pend_set addr 5, then write to 5 two cycles later: rs1_addr=5 gives rs1_busy=1 until the edge ending the wr_en cycle, then 0; pend_set 5 coincident with wr_en to 5 leaves busy=1.
- rst_n=0 for one cycle while a write is registered and pending_vec=8'hFF: next cycle wr_en=0, pend_vec=0, pointer=0.
- With R0_ZERO_EN: request to addr 0 is granted with no wr_en, and rs1_busy stays 0 after pend_set 0. Without it: wr_en=1 to addr 0 and busy behaves normally.
